// File: rtl/cold_buffer_pingpong.sv
// rtl/cold_buffer_pingpong.sv - double-banked row buffer between DMA fill and MLU read
// One bank fills while the other is read; banks swap on commit (wr_last) and release.
module cold_buffer_pingpong #(
    parameter  int DW    = 32,
    parameter  int LANES = 256,
    parameter  int DEPTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RW    = LANES * DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [RW-1:0] i_wr_data,
    input  logic          i_wr_last,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_rd_release,
    output logic          o_rd_avail,
    output logic          o_rd_valid,
    output logic [RW-1:0] o_rd_data,
    output logic [1:0]    o_banks_ready,
    output logic          o_err
);

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_READY = 1'b1
    } bank_state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Bank select is the MSB of the row index, so bank0 occupies the low half.
    logic [RW-1:0] r_mem [2**(AW+1)];

    bank_state_t   r_state [2];
    bank_state_t   w_state_nxt [2];
    logic          r_wp;
    logic          r_rp;
    logic          r_rd_valid;
    logic [RW-1:0] r_rd_data;
    logic [1:0]    r_banks_ready;
    logic          r_err;

    logic          w_wr_ready;
    logic          w_rd_avail;
    logic          w_wr_acc;
    logic          w_addr_ok;
    logic          w_commit;
    logic          w_release;
    logic          w_rd_fire;
    logic          w_err_evt;
    logic [1:0]    w_banks_nxt;

    assign w_wr_ready = (r_state[r_wp] == BANK_EMPTY);
    assign w_rd_avail = (r_state[r_rp] == BANK_READY);
    assign w_wr_acc   = i_wr_valid & w_wr_ready;
    assign w_addr_ok  = ({1'b0, i_wr_addr} < DEPTH_W);
    assign w_commit   = w_wr_acc & i_wr_last;
    assign w_release  = i_rd_release & w_rd_avail;
    assign w_rd_fire  = i_rd_en & w_rd_avail;
    assign w_err_evt  = (i_rd_en & ~w_rd_avail) | (i_rd_release & ~w_rd_avail)
                      | (w_wr_acc & ~w_addr_ok);

    // Commit targets an EMPTY bank and release a READY one, so they never collide.
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_commit) begin
            w_state_nxt[r_wp] = BANK_READY;
        end
        if (w_release) begin
            w_state_nxt[r_rp] = BANK_EMPTY;
        end
        w_banks_nxt = {1'b0, (w_state_nxt[0] == BANK_READY)}
                    + {1'b0, (w_state_nxt[1] == BANK_READY)};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state[0]    <= BANK_EMPTY;
            r_state[1]    <= BANK_EMPTY;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_banks_ready <= 2'd0;
            r_err         <= 1'b0;
        end else begin
            r_state[0]    <= w_state_nxt[0];
            r_state[1]    <= w_state_nxt[1];
            r_banks_ready <= w_banks_nxt;
            r_err         <= r_err | w_err_evt;
            if (w_commit) begin
                r_wp <= ~r_wp;
            end
            if (w_release) begin
                r_rp <= ~r_rp;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc && w_addr_ok) begin
            r_mem[{r_wp, i_wr_addr}] <= i_wr_data;
        end
    end

    // A read issued with release in the same cycle still sees the releasing bank.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= r_mem[{r_rp, i_rd_addr}];
            end
        end
    end

    assign o_wr_ready    = w_wr_ready;
    assign o_rd_avail    = w_rd_avail;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_banks_ready = r_banks_ready;
    assign o_err         = r_err;

endmodule

// File: tb/tb_cold_buffer_pingpong.sv
// tb/tb_cold_buffer_pingpong.sv - scoreboard bench for cold_buffer_pingpong
module tb_cold_buffer_pingpong;

    localparam int DW    = 32;
    localparam int LANES = 256;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RW    = DW * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          wr_last;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_release;
    logic          rd_avail;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic [1:0]    banks_ready;
    logic          err;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q [$];

    cold_buffer_pingpong dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_wr_last    (wr_last),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .i_rd_release (rd_release),
        .o_rd_avail   (rd_avail),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_banks_ready(banks_ready),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] make_row(input int addr, input int off);
        logic [RW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*DW +: DW] = 32'(addr * 256 + i + off);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input int off, input logic last);
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = make_row(addr, off);
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic fill_bank(input int off);
        for (int a = 0; a < DEPTH; a++) begin
            write_row(a, off, a == DEPTH - 1);
        end
    endtask

    // Issue a read that is expected to succeed; the monitor compares the row.
    task automatic read_row(input int addr, input int off, input logic rel);
        rd_en      = 1'b1;
        rd_addr    = AW'(addr);
        rd_release = rel;
        exp_q.push_back(make_row(addr, off));
        tick();
        rd_en      = 1'b0;
        rd_release = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got rd_valid=1 lane0=%0d expected no read", rd_data[31:0]);
            end else begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_row: got lane0=%0d lane255=%0d expected lane0=%0d lane255=%0d",
                             rd_data[31:0], rd_data[RW-1 -: DW], e[31:0], e[RW-1 -: DW]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_rd_avail", 32'(rd_avail), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data != '0), 0);
        chk("rst_banks", 32'(banks_ready), 0);
        chk("rst_err", 32'(err), 0);

        // Bank0 fill and commit
        fill_bank(0);
        chk("commit_rd_avail", 32'(rd_avail), 1);
        chk("commit_banks", 32'(banks_ready), 1);
        chk("commit_wr_ready", 32'(wr_ready), 1);
        read_row(5, 0, 1'b0);
        chk("rd5_valid", 32'(rd_valid), 1);
        chk("rd5_lane3", rd_data[3*DW +: DW], 1283);

        // Both banks full; held write must not land
        fill_bank(32'h10000);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("full_banks", 32'(banks_ready), 2);
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = {LANES{32'hDEAD_BEEF}}; wr_last = 1'b1;
        tick(); tick();
        chk("held_wr_ready", 32'(wr_ready), 0);
        read_row(5, 0, 1'b0);
        chk("held_not_written", rd_data[3*DW +: DW], 1283);
        wr_valid = 1'b0; wr_last = 1'b0;
        tick();
        chk("held_banks", 32'(banks_ready), 2);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        chk("rel_wr_ready", 32'(wr_ready), 1);
        chk("rel_banks", 32'(banks_ready), 1);
        chk("rel_rd_avail", 32'(rd_avail), 1);
        read_row(5, 32'h10000, 1'b0);
        chk("rd_bank1_lane3", rd_data[3*DW +: DW], 66819);

        // Refill bank0, then read+release on bank1 and bank0
        fill_bank(0);
        chk("refill_banks", 32'(banks_ready), 2);
        read_row(7, 32'h10000, 1'b1);
        chk("rr1_lane0", rd_data[31:0], 67328);
        chk("rr1_banks", 32'(banks_ready), 1);
        chk("rr1_rd_avail", 32'(rd_avail), 1);
        read_row(7, 0, 1'b1);
        chk("rr0_lane0", rd_data[31:0], 1792);
        chk("rr0_rd_avail", 32'(rd_avail), 0);
        chk("rr0_banks", 32'(banks_ready), 0);
        chk("rr0_wr_ready", 32'(wr_ready), 1);
        chk("rr0_err", 32'(err), 0);

        // Read with nothing available
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        rd_en = 1'b0;
        chk("bad_rd_valid", 32'(rd_valid), 0);
        chk("bad_rd_hold", rd_data[31:0], 1792);
        chk("bad_rd_err", 32'(err), 1);
        tick(); tick(); tick();
        chk("err_sticky", 32'(err), 1);

        // Reset mid-fill, then refill from row 0
        for (int a = 0; a < 10; a++) begin
            write_row(a, 32'h30000, 1'b0);
        end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst2_err", 32'(err), 0);
        chk("rst2_rd_avail", 32'(rd_avail), 0);
        chk("rst2_banks", 32'(banks_ready), 0);
        chk("rst2_wr_ready", 32'(wr_ready), 1);
        chk("rst2_rd_data", 32'(rd_data != '0), 0);
        fill_bank(32'h20000);
        chk("rst2_commit_avail", 32'(rd_avail), 1);
        chk("rst2_commit_banks", 32'(banks_ready), 1);
        read_row(0, 32'h20000, 1'b0);
        chk("rst2_row0_lane0", rd_data[31:0], 131072);
        read_row(31, 32'h20000, 1'b0);
        chk("rst2_row31_lane255", rd_data[RW-1 -: DW], 139263);
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
